// File: rtl/aemb_imem_slave_if.sv
// ---------------------------------------------------------------------------
// aemb_imem_slave_if
// Bundles the instruction-side Wishbone read port and the program load port
// of the instruction memory responder.
//
//   iwb_adr_i  ISIZ  byte address from the fetch unit (bits [1:0] ignored)
//   iwb_stb_i  1     read request strobe
//   iwb_ack_o  1     read data valid / transfer complete
//   iwb_dat_o  32    instruction word
//   ld_we_i    1     load-port write enable
//   ld_adr_i   AW    load-port word address
//   ld_dat_i   32    load-port write data
//
// master : fetch unit plus boot loader side
// slave  : memory side
// ---------------------------------------------------------------------------
interface aemb_imem_slave_if #(
   parameter int ISIZ = 32,
   parameter int AW   = 10
);
   logic [ISIZ-1:0] iwb_adr_i;
   logic            iwb_stb_i;
   logic            iwb_ack_o;
   logic [31:0]     iwb_dat_o;
   logic            ld_we_i;
   logic [AW-1:0]   ld_adr_i;
   logic [31:0]     ld_dat_i;

   modport master (
      output iwb_adr_i, iwb_stb_i, ld_we_i, ld_adr_i, ld_dat_i,
      input  iwb_ack_o, iwb_dat_o
   );

   modport slave (
      input  iwb_adr_i, iwb_stb_i, ld_we_i, ld_adr_i, ld_dat_i,
      output iwb_ack_o, iwb_dat_o
   );
endinterface

// File: rtl/aemb_imem_slave.sv
// ---------------------------------------------------------------------------
// aemb_imem_slave
// Synchronous instruction memory answering word-aligned Wishbone reads from
// the core fetch unit, with WAIT programmable wait states before the ack,
// and a side load port for writing program words.
// All registers update on the falling edge of nclk.
//
// Ports:
//   nclk  in   system clock (falling-edge active)
//   nrst  in   asynchronous active-low reset
//   bus   slave modport of aemb_imem_slave_if (read port + load port)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no access in progress
// S_WAIT | request latched, counting down wait states
// S_ACK  | iwb_ack_o high, iwb_dat_o holds the requested word
// ---------------------------------------------------------------------------
module aemb_imem_slave #(
   parameter int ISIZ = 32,
   parameter int AW   = 10,
   parameter int WAIT = 0
) (
   input  logic              nclk,
   input  logic              nrst,
   aemb_imem_slave_if.slave  bus
);

   localparam logic [3:0] WAIT_L = 4'(WAIT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt_nxt;
   logic [AW-1:0] r_idx;
   logic [AW-1:0] w_idx_nxt;
   logic [31:0]   r_dat;
   logic          w_rd_en;
   logic [AW-1:0] w_rd_idx;
   logic [AW-1:0] w_adr_idx;
   logic          w_unused_adr;

   logic [31:0]   r_mem [2**AW];

   // Upper address bits alias; the byte-lane bits are don't-care.
   assign w_adr_idx    = bus.iwb_adr_i[AW+1:2];
   assign w_unused_adr = ^{bus.iwb_adr_i[ISIZ-1:AW+2], bus.iwb_adr_i[1:0]};

   // Program store: no reset. A read issued on the same edge as a write to
   // the same word sees the old contents because both use edge-sampled values.
   always_ff @(negedge nclk) begin
      if (bus.ld_we_i) begin
         r_mem[bus.ld_adr_i] <= bus.ld_dat_i;
      end
   end

   always_ff @(negedge nclk or negedge nrst) begin
      if (!nrst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_dat   <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         if (w_rd_en) begin
            r_dat <= r_mem[w_rd_idx];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_rd_en     = 1'b0;
      w_rd_idx    = r_idx;
      case (r_state)
         // ACK accepts a back-to-back request exactly like IDLE.
         S_IDLE, S_ACK: begin
            if (bus.iwb_stb_i) begin
               w_idx_nxt = w_adr_idx;
               if (WAIT_L == 4'd0) begin
                  w_state_nxt = S_ACK;
                  w_rd_en     = 1'b1;
                  w_rd_idx    = w_adr_idx;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = WAIT_L;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (!bus.iwb_stb_i) begin
               // Abort: drop the request, leave the output word untouched.
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end else if (r_cnt == 4'd1) begin
               w_state_nxt = S_ACK;
               w_cnt_nxt   = 4'd0;
               w_rd_en     = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   assign bus.iwb_ack_o = (r_state == S_ACK);
   assign bus.iwb_dat_o = r_dat;

endmodule

// File: tb/tb_aemb_imem_slave.sv
// ---------------------------------------------------------------------------
// tb_aemb_imem_slave
// Three instances (WAIT = 0, 3, 5) share one stimulus stream. Inputs change
// and outputs are sampled on the rising edge, away from the active falling
// edge. A transaction-level reference model tracks each instance.
// ---------------------------------------------------------------------------
module tb_aemb_imem_slave;

   logic        nclk = 1'b1;
   logic        nrst;
   logic [31:0] adr;
   logic        stb;
   logic        we;
   logic [9:0]  ladr;
   logic [31:0] ldat;

   int n_checks = 0;
   int n_errors = 0;

   always #5 nclk = ~nclk;

   aemb_imem_slave_if #(.ISIZ(32), .AW(10)) i0 ();
   aemb_imem_slave_if #(.ISIZ(32), .AW(10)) i3 ();
   aemb_imem_slave_if #(.ISIZ(32), .AW(10)) i5 ();

   assign i0.iwb_adr_i = adr;  assign i3.iwb_adr_i = adr;  assign i5.iwb_adr_i = adr;
   assign i0.iwb_stb_i = stb;  assign i3.iwb_stb_i = stb;  assign i5.iwb_stb_i = stb;
   assign i0.ld_we_i   = we;   assign i3.ld_we_i   = we;   assign i5.ld_we_i   = we;
   assign i0.ld_adr_i  = ladr; assign i3.ld_adr_i  = ladr; assign i5.ld_adr_i  = ladr;
   assign i0.ld_dat_i  = ldat; assign i3.ld_dat_i  = ldat; assign i5.ld_dat_i  = ldat;

   aemb_imem_slave #(.ISIZ(32), .AW(10), .WAIT(0)) u0 (.nclk(nclk), .nrst(nrst), .bus(i0));
   aemb_imem_slave #(.ISIZ(32), .AW(10), .WAIT(3)) u3 (.nclk(nclk), .nrst(nrst), .bus(i3));
   aemb_imem_slave #(.ISIZ(32), .AW(10), .WAIT(5)) u5 (.nclk(nclk), .nrst(nrst), .bus(i5));

   logic        d_ack [3];
   logic [31:0] d_dat [3];
   assign d_ack[0] = i0.iwb_ack_o; assign d_dat[0] = i0.iwb_dat_o;
   assign d_ack[1] = i3.iwb_ack_o; assign d_dat[1] = i3.iwb_dat_o;
   assign d_ack[2] = i5.iwb_ack_o; assign d_dat[2] = i5.iwb_dat_o;

   // ---------------- reference model ----------------
   // Each instance either has a request in flight (with a count of edges
   // still to elapse before its word is fetched) or not; the ack is simply
   // "a word was delivered at the last edge".
   localparam int WAITS [3] = '{0, 3, 5};
   logic [31:0] m_mem [1024];
   logic        m_ack [3];
   logic [31:0] m_dat [3];
   logic        m_busy [3];
   int          m_left [3];
   int          m_word [3];

   always @(negedge nclk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < 3; i++) begin
            m_ack[i]  <= 1'b0;
            m_dat[i]  <= 32'h0;
            m_busy[i] <= 1'b0;
            m_left[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (m_busy[i]) begin
               if (!stb) begin
                  m_busy[i] <= 1'b0;
               end else if (m_left[i] == 1) begin
                  m_busy[i] <= 1'b0;
                  m_ack[i]  <= 1'b1;
                  m_dat[i]  <= m_mem[m_word[i]];
               end else begin
                  m_left[i] <= m_left[i] - 1;
               end
            end else if (stb) begin
               if (WAITS[i] == 0) begin
                  m_ack[i] <= 1'b1;
                  m_dat[i] <= m_mem[(adr >> 2) % 1024];
               end else begin
                  m_ack[i]  <= 1'b0;
                  m_busy[i] <= 1'b1;
                  m_left[i] <= WAITS[i];
                  m_word[i] <= int'((adr >> 2) % 1024);
               end
            end else begin
               m_ack[i] <= 1'b0;
            end
         end
         if (we) m_mem[ladr] <= ldat;
      end
   end

   // ---------------- drivers ----------------
   task automatic load_word(input logic [9:0] a, input logic [31:0] d);
      we = 1'b1; ladr = a; ldat = d;
      @(posedge nclk);
      we = 1'b0;
   endtask

   task automatic idle_cycle();
      stb = 1'b0;
      @(posedge nclk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(posedge nclk);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (d_ack[i] !== 1'b0 || d_dat[i] !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_hold[%0d]: ack=%b dat=%h, required ack=0 dat=00000000", i, d_ack[i], d_dat[i]);
         end
      end
      nrst = 1'b1;
      @(posedge nclk);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (d_ack[i] !== 1'b0 || d_dat[i] !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_release[%0d]: ack=%b dat=%h, required ack=0 dat=00000000", i, d_ack[i], d_dat[i]);
         end
      end
   endtask

   task automatic test_burst();
      logic [31:0] words [4];
      words = '{32'hB0000000, 32'h11223344, 32'hDEADBEEF, 32'hA5A5A5A5};
      stb = 1'b1; adr = 32'h0;
      for (int k = 0; k < 4; k++) begin
         @(posedge nclk);
         n_checks++;
         if (d_ack[0] !== 1'b1 || d_dat[0] !== words[k]) begin
            n_errors++;
            $display("FAIL burst[%0d]: ack=%b dat=%h, required ack=1 dat=%h", k, d_ack[0], d_dat[0], words[k]);
         end
         if (k < 3) adr = 32'((k + 1) * 4);
         else stb = 1'b0;
      end
      @(posedge nclk);
      n_checks++;
      if (d_ack[0] !== 1'b0 || d_dat[0] !== 32'hA5A5A5A5) begin
         n_errors++;
         $display("FAIL burst_end: ack=%b dat=%h, required ack=0 dat=a5a5a5a5", d_ack[0], d_dat[0]);
      end
   endtask

   task automatic test_wait3();
      stb = 1'b1; adr = 32'h8;
      for (int k = 0; k < 3; k++) begin
         @(posedge nclk);
         n_checks++;
         if (d_ack[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL wait3_low[%0d]: ack=%b, required 0", k, d_ack[1]);
         end
      end
      @(posedge nclk);
      n_checks++;
      if (d_ack[1] !== 1'b1 || d_dat[1] !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL wait3_ack: ack=%b dat=%h, required ack=1 dat=deadbeef", d_ack[1], d_dat[1]);
      end
      stb = 1'b0;
      @(posedge nclk);
      n_checks++;
      if (d_ack[1] !== 1'b0) begin
         n_errors++;
         $display("FAIL wait3_drop: ack=%b, required 0", d_ack[1]);
      end
   endtask

   task automatic test_abort();
      stb = 1'b1; adr = 32'hC;
      @(posedge nclk);
      stb = 1'b0;
      @(posedge nclk);
      n_checks++;
      if (d_ack[1] !== 1'b0 || d_dat[1] !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL abort_idle: ack=%b dat=%h, required ack=0 dat=deadbeef", d_ack[1], d_dat[1]);
      end
      stb = 1'b1; adr = 32'h4;
      for (int k = 0; k < 3; k++) begin
         @(posedge nclk);
         n_checks++;
         if (d_ack[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_retry_low[%0d]: ack=%b, required 0", k, d_ack[1]);
         end
      end
      @(posedge nclk);
      n_checks++;
      if (d_ack[1] !== 1'b1 || d_dat[1] !== 32'h11223344) begin
         n_errors++;
         $display("FAIL abort_retry_ack: ack=%b dat=%h, required ack=1 dat=11223344", d_ack[1], d_dat[1]);
      end
      idle_cycle();
   endtask

   task automatic test_alias();
      stb = 1'b1; adr = 32'h00001004;
      @(posedge nclk);
      n_checks++;
      if (d_ack[0] !== 1'b1 || d_dat[0] !== 32'h11223344) begin
         n_errors++;
         $display("FAIL alias: ack=%b dat=%h, required ack=1 dat=11223344", d_ack[0], d_dat[0]);
      end
      idle_cycle();
   endtask

   task automatic test_collision();
      stb = 1'b1; adr = 32'h8;
      we = 1'b1; ladr = 10'd2; ldat = 32'hCAFEF00D;
      @(posedge nclk);
      we = 1'b0;
      n_checks++;
      if (d_ack[0] !== 1'b1 || d_dat[0] !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL collision_old: ack=%b dat=%h, required ack=1 dat=deadbeef", d_ack[0], d_dat[0]);
      end
      @(posedge nclk);
      n_checks++;
      if (d_ack[0] !== 1'b1 || d_dat[0] !== 32'hCAFEF00D) begin
         n_errors++;
         $display("FAIL collision_new: ack=%b dat=%h, required ack=1 dat=cafef00d", d_ack[0], d_dat[0]);
      end
      idle_cycle();
   endtask

   task automatic test_reset_mid();
      int  k;
      bit  got;
      stb = 1'b1; adr = 32'hC;
      @(posedge nclk);
      @(posedge nclk);
      n_checks++;
      if (d_ack[2] !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_wait: ack=%b, required 0", d_ack[2]);
      end
      #2 nrst = 1'b0;
      #1;
      n_checks++;
      if (d_ack[2] !== 1'b0 || d_dat[2] !== 32'h0 || d_dat[0] !== 32'h0) begin
         n_errors++;
         $display("FAIL rstmid_async: ack5=%b dat5=%h dat0=%h, required 0/00000000/00000000", d_ack[2], d_dat[2], d_dat[0]);
      end
      stb = 1'b0;
      @(posedge nclk);
      nrst = 1'b1;
      @(posedge nclk);
      stb = 1'b1; adr = 32'h0;
      got = 1'b0;
      k = 0;
      while (k < 10 && !got) begin
         @(posedge nclk);
         if (d_ack[2] === 1'b1) got = 1'b1;
         else k++;
      end
      n_checks++;
      if (!got || k != 5 || d_dat[2] !== 32'hB0000000) begin
         n_errors++;
         $display("FAIL rstmid_reread: got=%b wait_cycles=%0d dat=%h, required got=1 wait_cycles=5 dat=b0000000", got, k, d_dat[2]);
      end
      idle_cycle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         stb  = ($urandom_range(0, 3) != 0);
         adr  = $urandom;
         we   = ($urandom_range(0, 2) == 0);
         ladr = 10'($urandom);
         ldat = $urandom;
         @(posedge nclk);
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (d_ack[i] !== m_ack[i] || (m_ack[i] && d_dat[i] !== m_dat[i])) begin
               n_errors++;
               $display("FAIL random[%0d] dut%0d: ack=%b dat=%h, required ack=%b dat=%h", c, i, d_ack[i], d_dat[i], m_ack[i], m_dat[i]);
            end
         end
      end
      stb = 1'b0; we = 1'b0;
      @(posedge nclk);
   endtask

   initial begin
      nrst = 1'b0; stb = 1'b0; adr = 32'h0; we = 1'b0; ladr = 10'h0; ldat = 32'h0;
      test_reset();
      for (int a = 0; a < 1024; a++) load_word(10'(a), $urandom);
      load_word(10'd0, 32'hB0000000);
      load_word(10'd1, 32'h11223344);
      load_word(10'd2, 32'hDEADBEEF);
      load_word(10'd3, 32'hA5A5A5A5);
      test_burst();
      test_wait3();
      test_abort();
      test_alias();
      test_collision();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
